// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and parameter checks for the multicycle adder
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } madd_state_e;

    function automatic bit madd_params_ok(input int n, input int w);
        return (w >= 1) && (w <= n) && ((n % w) == 0);
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - combinational N-bit ripple-carry adder slice
module ripple_carry_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_carry,
    output logic [N-1:0] o_sum,
    output logic         o_carry
);

    logic [N:0] w_c;

    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_carry;
        for (int i = 0; i < N; i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
        o_carry = w_c[N];
    end

endmodule

// File: rtl/multicycle_adder.sv
// rtl/multicycle_adder.sv - digit-serial add/sub, W bits per cycle, valid/ready on both sides
module multicycle_adder
    import arith_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int STEPS = N / W;
    localparam int CW    = $clog2(STEPS + 1);

    if (!madd_params_ok(N, W)) begin : g_param_check
        $error("multicycle_adder: W must satisfy 1 <= W <= N and N %% W == 0");
    end

    madd_state_e   r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_x;
    logic [N-1:0]  r_y;
    logic          r_carry;
    logic          r_xmsb;
    logic          r_ymsb;
    logic [N-1:0]  r_s;
    logic          r_cout;
    logic          r_ovf;

    logic [W-1:0]  w_sum;
    logic          w_carry_next;
    logic [N-1:0]  w_x_next;
    logic [N-1:0]  w_y_next;
    logic          w_last;

    ripple_carry_adder #(.N(W)) u_slice (
        .i_a     (r_x[W-1:0]),
        .i_b     (r_y[W-1:0]),
        .i_carry (r_carry),
        .o_sum   (w_sum),
        .o_carry (w_carry_next)
    );

    // r_x doubles as the result accumulator: consumed digits leave the bottom, sums enter the top.
    if (W == N) begin : g_single_step
        assign w_x_next = w_sum;
        assign w_y_next = '0;
    end else begin : g_multi_step
        assign w_x_next = {w_sum, r_x[N-1:W]};
        assign w_y_next = {{W{1'b0}}, r_y[N-1:W]};
    end

    assign w_last    = (r_cnt == CW'(STEPS - 1));
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_carry <= 1'b0;
            r_xmsb  <= 1'b0;
            r_ymsb  <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x     <= x;
                        r_y     <= sub ? ~y : y;
                        r_carry <= cin ^ sub;
                        r_xmsb  <= x[N-1];
                        r_ymsb  <= sub ? ~y[N-1] : y[N-1];
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_x     <= w_x_next;
                    r_y     <= w_y_next;
                    r_carry <= w_carry_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_s     <= w_x_next;
                        r_cout  <= w_carry_next;
                        r_ovf   <= (r_xmsb == r_ymsb) && (w_x_next[N-1] != r_xmsb);
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// tb/tb_multicycle_adder.sv - directed and randomized checks of multicycle_adder at W=8, W=1, W=32
module tb_multicycle_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] x_i       [3];
    logic [31:0] y_i       [3];
    logic        cin_i     [3];
    logic        sub_i     [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] s_o       [3];
    logic        cout_o    [3];
    logic        ovf_o     [3];

    int checks = 0;
    int errors = 0;
    int steps_of [3] = '{4, 32, 1};

    always #5 clk = ~clk;

    multicycle_adder #(.N(32), .W(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x(x_i[0]), .y(y_i[0]), .cin(cin_i[0]), .sub(sub_i[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .s(s_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0])
    );

    multicycle_adder #(.N(32), .W(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x(x_i[1]), .y(y_i[1]), .cin(cin_i[1]), .sub(sub_i[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .s(s_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1])
    );

    multicycle_adder #(.N(32), .W(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .x(x_i[2]), .y(y_i[2]), .cin(cin_i[2]), .sub(sub_i[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .s(s_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-precision integer arithmetic, {ovf, cout, s}
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic sb);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sbv = longint'($signed(b));
        longint lc = longint'(c);
        longint ur;
        longint sr;
        logic   co;
        logic   ov;
        if (!sb) begin
            ur = ua + ub + lc;
            sr = sa + sbv + lc;
            co = (ur >= (longint'(1) << 32));
        end else begin
            ur = ua - ub - lc;
            sr = sa - sbv - lc;
            co = (ur >= 0);
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {ov, co, ur[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Called at the first negedge after the accept edge.
    task automatic wait_result(input int d, input logic [31:0] es, input logic ec, input logic eo);
        int n = 0;
        while (!out_valid[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(steps_of[d]));
        check("s", s_o[d], es);
        check("cout", cout_o[d], ec);
        check("ovf", ovf_o[d], eo);
    endtask

    task automatic finish_op(input int d, input logic [31:0] es, input int stall);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("hold_s", s_o[d], es);
            check("hold_valid", out_valid[d], 1'b1);
        end
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        check("idle_ready", in_ready[d], 1'b1);
        check("idle_valid", out_valid[d], 1'b0);
        check("idle_s", s_o[d], es);
    endtask

    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic sb,
                          input logic [31:0] es, input logic ec, input logic eo, input int stall);
        int n = 0;
        @(negedge clk);
        x_i[d] = a; y_i[d] = b; cin_i[d] = c; sub_i[d] = sb;
        in_valid[d] = 1'b1;
        while (!in_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", in_ready[d], 1'b1);
        @(negedge clk);
        in_valid[d] = 1'b0;
        x_i[d] = $urandom(); y_i[d] = $urandom();
        wait_result(d, es, ec, eo);
        finish_op(d, es, stall);
    endtask

    initial begin
        logic [33:0] m;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        sb;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b0;
            x_i[d] = '0; y_i[d] = '0; cin_i[d] = 1'b0; sub_i[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_in_ready", in_ready[d], 1'b1);
            check("rst_out_valid", out_valid[d], 1'b0);
            check("rst_s", s_o[d], 32'h0);
            check("rst_cout", cout_o[d], 1'b0);
            check("rst_ovf", ovf_o[d], 1'b0);
        end
        rst = 1'b0;

        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0);
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1);
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 0);
        run_op(0, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 2);
        run_op(0, 32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 1'b0, 0);

        // Back-pressure in DONE with a competing request held high
        @(negedge clk);
        x_i[0] = 32'h1; y_i[0] = 32'h2; cin_i[0] = 1'b0; sub_i[0] = 1'b0; in_valid[0] = 1'b1;
        @(negedge clk);
        x_i[0] = 32'h100; y_i[0] = 32'h23;
        wait_result(0, 32'h3, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_s", s_o[0], 32'h3);
            check("bp_cout", cout_o[0], 1'b0);
            check("bp_in_ready", in_ready[0], 1'b0);
            check("bp_out_valid", out_valid[0], 1'b1);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("bp_idle_ready", in_ready[0], 1'b1);
        check("bp_idle_valid", out_valid[0], 1'b0);
        @(negedge clk);
        in_valid[0] = 1'b0;
        check("bp_accepted", in_ready[0], 1'b0);
        wait_result(0, 32'h123, 1'b0, 1'b0);
        finish_op(0, 32'h123, 0);

        // Reset after the second RUN edge
        @(negedge clk);
        x_i[0] = 32'h5; y_i[0] = 32'h6; in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", in_ready[0], 1'b1);
        check("mid_rst_out_valid", out_valid[0], 1'b0);
        check("mid_rst_s", s_o[0], 32'h0);
        run_op(0, 32'h3, 32'h4, 1'b0, 1'b0, 32'h7, 1'b0, 1'b0, 0);

        for (int d = 1; d < 3; d++) begin
            for (int i = 0; i < 1000; i++) begin
                a  = pick();
                b  = pick();
                c  = 1'($urandom_range(0, 1));
                sb = 1'($urandom_range(0, 1));
                m  = model(a, b, c, sb);
                run_op(d, a, b, c, sb, m[31:0], m[32], m[33], $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
